recovery_sequencer: RTL and testbench

RECOVERY_SEQUENCER -- requirements
Module: recovery_sequencer

---
 rtl/recovery_sequencer_pkg.sv | 21 ++
 rtl/recovery_sequencer.sv | 131 +++++++++++++
 tb/tb_recovery_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/recovery_sequencer_pkg.sv
// Shared types for the mispredict recovery sequencer: address and
// register-index widths, default lane/register counts and the FSM state.
package recovery_sequencer_pkg;

  localparam int COMMIT_WIDTH = 3;
  localparam int ARCH_REG_SZ  = 32;
  localparam int ADDR_W       = 32;
  localparam int REG_IDX_W    = $clog2(ARCH_REG_SZ);

  typedef logic [ADDR_W-1:0]    addr_t;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    RESTORE,
    DRAIN,
    REDIRECT
  } recov_state_t;

endpackage

// File: rtl/recovery_sequencer.sv
// Mispredict recovery: squash the ROB, rebuild the map table from the
// architected map N lanes per beat, wait for the pipe to drain, then redirect fetch.
module recovery_sequencer
  import recovery_sequencer_pkg::*;
#(
  parameter int N          = COMMIT_WIDTH,
  parameter int ARCH_COUNT = ARCH_REG_SZ
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 recover_req,
  input  addr_t                recover_target,
  input  logic                 pipe_busy,
  output logic                 stall_front,
  output logic                 rob_flush,
  output logic                 fl_restore,
  output logic     [N-1:0]     mt_restore_en,
  output reg_idx_t [N-1:0]     mt_restore_idx,
  output logic                 redirect_valid,
  output addr_t                redirect_pc,
  output logic                 req_dropped
);

  // Sized to hold ARCH_COUNT+N so the last-beat compare never wraps.
  localparam int BASE_W = $clog2(ARCH_COUNT + N + 1);
  localparam logic [BASE_W-1:0] LANES = BASE_W'(N);
  localparam logic [BASE_W-1:0] LIMIT = BASE_W'(ARCH_COUNT);

  recov_state_t        state_reg;
  logic [BASE_W-1:0]   base_reg;
  addr_t               target_reg;
  logic                stall_reg;
  logic                flush_reg;
  logic                redirect_reg;
  logic     [N-1:0]    en_reg;
  reg_idx_t [N-1:0]    idx_reg;

  logic [BASE_W-1:0]   beat_base_next;
  logic     [N-1:0]    lane_en_next;
  reg_idx_t [N-1:0]    lane_idx_next;
  logic                last_beat;

  // Outputs are registered, so lanes are computed for the beat about to be presented.
  always_comb begin
    beat_base_next = '0;
    if (state_reg == RESTORE) beat_base_next = base_reg + LANES;
  end

  assign last_beat = (base_reg + LANES) >= LIMIT;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      logic [BASE_W-1:0] lane_reg_num;
      assign lane_reg_num      = beat_base_next + BASE_W'(gi);
      assign lane_en_next[gi]  = lane_reg_num < LIMIT;
      assign lane_idx_next[gi] = reg_idx_t'(lane_reg_num);
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= IDLE;
      base_reg     <= '0;
      target_reg   <= '0;
      stall_reg    <= 1'b0;
      flush_reg    <= 1'b0;
      redirect_reg <= 1'b0;
      en_reg       <= '0;
      idx_reg      <= '0;
    end else begin
      flush_reg    <= 1'b0;
      redirect_reg <= 1'b0;
      en_reg       <= '0;
      idx_reg      <= '0;
      case (state_reg)
        IDLE: begin
          if (recover_req) begin
            state_reg  <= FLUSH;
            target_reg <= recover_target;
            stall_reg  <= 1'b1;
            flush_reg  <= 1'b1;
          end
        end
        FLUSH: begin
          state_reg <= RESTORE;
          base_reg  <= '0;
          en_reg    <= lane_en_next;
          idx_reg   <= lane_idx_next;
        end
        RESTORE: begin
          if (last_beat) begin
            state_reg <= DRAIN;
            base_reg  <= '0;
          end else begin
            base_reg <= base_reg + LANES;
            en_reg   <= lane_en_next;
            idx_reg  <= lane_idx_next;
          end
        end
        DRAIN: begin
          if (!pipe_busy) begin
            state_reg    <= REDIRECT;
            redirect_reg <= 1'b1;
          end
        end
        REDIRECT: begin
          state_reg <= IDLE;
          stall_reg <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          stall_reg <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    req_dropped = 1'b0;
    if (recover_req && !reset && state_reg != IDLE) req_dropped = 1'b1;
  end

  assign stall_front    = stall_reg;
  assign rob_flush      = flush_reg;
  assign fl_restore     = flush_reg;
  assign mt_restore_en  = en_reg;
  assign mt_restore_idx = idx_reg;
  assign redirect_valid = redirect_reg;
  assign redirect_pc    = target_reg;

endmodule

// File: tb/tb_recovery_sequencer.sv
// Self-checking bench for recovery_sequencer: directed scenarios plus randomized
// recoveries checked against a timeline model (offsets from the accepted request).
module tb_recovery_sequencer;

  localparam int N  = 3;
  localparam int AC = 32;
  localparam int B  = (AC + N - 1) / N;  // restore beats

  logic              clock = 1'b0;
  logic              reset;
  logic              recover_req;
  logic [31:0]       recover_target;
  logic              pipe_busy;
  logic              stall_front;
  logic              rob_flush;
  logic              fl_restore;
  logic [N-1:0]      mt_restore_en;
  logic [N-1:0][4:0] mt_restore_idx;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              req_dropped;

  int n_checks = 0;
  int n_fail   = 0;

  recovery_sequencer #(.N(N), .ARCH_COUNT(AC)) dut (
    .clock(clock), .reset(reset), .recover_req(recover_req),
    .recover_target(recover_target), .pipe_busy(pipe_busy),
    .stall_front(stall_front), .rob_flush(rob_flush), .fl_restore(fl_restore),
    .mt_restore_en(mt_restore_en), .mt_restore_idx(mt_restore_idx),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .req_dropped(req_dropped)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

  // Outputs are sampled 1 time unit after the rising edge, inputs driven right after.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; recover_req = 1'b0; recover_target = '0; pipe_busy = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({stall_front, rob_flush, fl_restore, mt_restore_en, redirect_valid, req_dropped} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b exp=0",
               {stall_front, rob_flush, fl_restore, mt_restore_en, redirect_valid, req_dropped});
    end
    n_checks++;
    if (redirect_pc !== 32'h0) begin
      n_fail++; $display("FAIL reset_redirect_pc got=%h exp=00000000", redirect_pc);
    end
    reset = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int base;
    logic [N-1:0] exp_en;
    tick();
    recover_req = 1'b1; recover_target = 32'h1000; pipe_busy = 1'b0;
    for (int rel = 1; rel <= 16; rel++) begin
      tick();
      recover_req = 1'b0;
      n_checks++;
      if (stall_front !== (rel <= 14)) begin
        n_fail++; $display("FAIL basic_stall rel=%0d got=%b exp=%b", rel, stall_front, rel <= 14);
      end
      n_checks++;
      if (rob_flush !== (rel == 1) || fl_restore !== (rel == 1)) begin
        n_fail++; $display("FAIL basic_flush rel=%0d got=%b%b exp=%b", rel, rob_flush, fl_restore, rel == 1);
      end
      n_checks++;
      if (redirect_valid !== (rel == 14)) begin
        n_fail++; $display("FAIL basic_redirect_valid rel=%0d got=%b exp=%b", rel, redirect_valid, rel == 14);
      end
      exp_en = '0;
      base = (rel - 2) * N;
      if (rel >= 2 && rel <= B + 1)
        for (int w = 0; w < N; w++) exp_en[w] = (base + w < AC);
      n_checks++;
      if (mt_restore_en !== exp_en) begin
        n_fail++; $display("FAIL basic_restore_en rel=%0d got=%b exp=%b", rel, mt_restore_en, exp_en);
      end
      for (int w = 0; w < N; w++)
        if (exp_en[w]) begin
          n_checks++;
          if (mt_restore_idx[w] !== 5'(base + w)) begin
            n_fail++; $display("FAIL basic_restore_idx rel=%0d lane=%0d got=%0d exp=%0d",
                               rel, w, mt_restore_idx[w], base + w);
          end
        end
      if (rel == 12) begin
        n_checks++;
        if (mt_restore_en !== 3'b011 || mt_restore_idx[0] !== 5'd30 || mt_restore_idx[1] !== 5'd31) begin
          n_fail++; $display("FAIL basic_last_beat got en=%b idx1=%0d idx0=%0d exp en=011 idx1=31 idx0=30",
                             mt_restore_en, mt_restore_idx[1], mt_restore_idx[0]);
        end
      end
      if (rel == 14) begin
        n_checks++;
        if (redirect_pc !== 32'h1000) begin
          n_fail++; $display("FAIL basic_redirect_pc got=%h exp=00001000", redirect_pc);
        end
      end
    end
    $display("test_basic done");
  endtask

  task automatic test_drain_busy();
    tick();
    recover_req = 1'b1; recover_target = 32'h1000; pipe_busy = 1'b1;
    for (int rel = 1; rel <= 19; rel++) begin
      tick();
      recover_req = 1'b0;
      pipe_busy = (rel <= 16);
      n_checks++;
      if (stall_front !== (rel <= 18)) begin
        n_fail++; $display("FAIL drain_stall rel=%0d got=%b exp=%b", rel, stall_front, rel <= 18);
      end
      n_checks++;
      if (redirect_valid !== (rel == 18)) begin
        n_fail++; $display("FAIL drain_redirect_valid rel=%0d got=%b exp=%b", rel, redirect_valid, rel == 18);
      end
    end
    pipe_busy = 1'b0;
    $display("test_drain_busy done");
  endtask

  task automatic test_dropped();
    tick();
    recover_req = 1'b1; recover_target = 32'h1000; pipe_busy = 1'b0;
    #1;
    n_checks++;
    if (req_dropped !== 1'b0) begin
      n_fail++; $display("FAIL drop_accept got=%b exp=0", req_dropped);
    end
    for (int rel = 1; rel <= 16; rel++) begin
      tick();
      if (rel == 14) begin
        n_checks++;
        if (redirect_pc !== 32'h1000 || redirect_valid !== 1'b1) begin
          n_fail++; $display("FAIL drop_redirect got valid=%b pc=%h exp valid=1 pc=00001000",
                             redirect_valid, redirect_pc);
        end
      end
      if (rel >= 15) begin
        n_checks++;
        if (stall_front !== 1'b0 || rob_flush !== 1'b0) begin
          n_fail++; $display("FAIL drop_no_restart rel=%0d got stall=%b flush=%b exp 0 0",
                             rel, stall_front, rob_flush);
        end
      end
      recover_req = (rel == 5 || rel == 14);
      recover_target = (rel == 5) ? 32'h2000 : 32'h3000;
      #1;
      n_checks++;
      if (req_dropped !== (rel == 5 || rel == 14)) begin
        n_fail++; $display("FAIL drop_pulse rel=%0d got=%b exp=%b", rel, req_dropped, rel == 5 || rel == 14);
      end
    end
    recover_req = 1'b0;
    $display("test_dropped done");
  endtask

  task automatic test_reset_midway();
    logic seen;
    tick();
    recover_req = 1'b1; recover_target = 32'h3000; pipe_busy = 1'b0;
    repeat (6) tick();
    recover_req = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if ({stall_front, rob_flush, fl_restore, mt_restore_en, redirect_valid} !== '0 || redirect_pc !== 32'h0) begin
      n_fail++; $display("FAIL midreset_outputs got=%b pc=%h exp=0 pc=00000000",
                         {stall_front, rob_flush, fl_restore, mt_restore_en, redirect_valid}, redirect_pc);
    end
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (stall_front || rob_flush || redirect_valid || mt_restore_en != '0) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL midreset_pending_pulse got=%b exp=0", seen);
    end
    recover_req = 1'b1; recover_target = 32'h4000;
    for (int rel = 1; rel <= 15; rel++) begin
      tick();
      recover_req = 1'b0;
      n_checks++;
      if (redirect_valid !== (rel == 14) || stall_front !== (rel <= 14)) begin
        n_fail++; $display("FAIL midreset_rerun rel=%0d got valid=%b stall=%b exp valid=%b stall=%b",
                           rel, redirect_valid, stall_front, rel == 14, rel <= 14);
      end
      if (rel == 14) begin
        n_checks++;
        if (redirect_pc !== 32'h4000) begin
          n_fail++; $display("FAIL midreset_rerun_pc got=%h exp=00004000", redirect_pc);
        end
      end
    end
    $display("test_reset_midway done");
  endtask

  task automatic test_req_with_reset();
    logic seen;
    tick();
    reset = 1'b1; recover_req = 1'b1; recover_target = 32'h5000;
    tick();
    reset = 1'b0; recover_req = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (rob_flush || stall_front) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL reqreset_flush_seen got=%b exp=0", seen);
    end
    n_checks++;
    if (redirect_pc !== 32'h0) begin
      n_fail++; $display("FAIL reqreset_target got=%h exp=00000000", redirect_pc);
    end
    $display("test_req_with_reset done");
  endtask

  task automatic test_random();
    logic [31:0]  target, prev_target;
    logic [N-1:0] exp_en;
    int d, gap, drop_rel, total, base, bad;
    prev_target = redirect_pc;
    for (int t = 0; t < 20; t++) begin
      target   = $urandom;
      d        = $urandom_range(1, 6);
      gap      = $urandom_range(0, 3);
      total    = B + d + 2;
      drop_rel = $urandom_range(1, total);
      bad      = 0;
      tick();
      n_checks++;
      if (stall_front !== 1'b0 || rob_flush !== 1'b0 || redirect_pc !== prev_target) begin
        n_fail++; bad++;
        $display("FAIL rand_idle txn=%0d got stall=%b flush=%b pc=%h exp 0 0 %h",
                 t, stall_front, rob_flush, redirect_pc, prev_target);
      end
      recover_req = 1'b1; recover_target = target; pipe_busy = 1'($urandom);
      #1;
      n_checks++;
      if (req_dropped !== 1'b0) begin
        n_fail++; bad++; $display("FAIL rand_accept txn=%0d got=%b exp=0", t, req_dropped);
      end
      for (int rel = 1; rel <= total; rel++) begin
        tick();
        exp_en = '0;
        base = (rel - 2) * N;
        if (rel >= 2 && rel <= B + 1)
          for (int w = 0; w < N; w++) exp_en[w] = (base + w < AC);
        n_checks++;
        if (stall_front !== 1'b1 || rob_flush !== (rel == 1) || fl_restore !== (rel == 1) ||
            redirect_valid !== (rel == total) || mt_restore_en !== exp_en) begin
          n_fail++; bad++;
          $display("FAIL rand_outputs txn=%0d rel=%0d got stall=%b flush=%b fl=%b rv=%b en=%b exp 1 %b %b %b %b",
                   t, rel, stall_front, rob_flush, fl_restore, redirect_valid, mt_restore_en,
                   rel == 1, rel == 1, rel == total, exp_en);
        end
        for (int w = 0; w < N; w++)
          if (exp_en[w]) begin
            n_checks++;
            if (mt_restore_idx[w] !== 5'(base + w)) begin
              n_fail++; bad++;
              $display("FAIL rand_idx txn=%0d rel=%0d lane=%0d got=%0d exp=%0d",
                       t, rel, w, mt_restore_idx[w], base + w);
            end
          end
        if (rel == total) begin
          n_checks++;
          if (redirect_pc !== target) begin
            n_fail++; bad++; $display("FAIL rand_pc txn=%0d got=%h exp=%h", t, redirect_pc, target);
          end
        end
        recover_req = (rel == drop_rel);
        if (rel == drop_rel) recover_target = $urandom;
        if (rel >= B + 2 && rel <= B + d) pipe_busy = 1'b1;
        else if (rel == B + 1 + d)        pipe_busy = 1'b0;
        else                              pipe_busy = 1'($urandom);
        #1;
        n_checks++;
        if (req_dropped !== (rel == drop_rel)) begin
          n_fail++; bad++;
          $display("FAIL rand_drop txn=%0d rel=%0d got=%b exp=%b", t, rel, req_dropped, rel == drop_rel);
        end
      end
      recover_req = 1'b0;
      repeat (gap) begin
        tick();
        n_checks++;
        if ({stall_front, rob_flush, fl_restore, mt_restore_en, redirect_valid} !== '0 || redirect_pc !== target) begin
          n_fail++; bad++;
          $display("FAIL rand_gap txn=%0d got=%b pc=%h exp=0 pc=%h",
                   t, {stall_front, rob_flush, fl_restore, mt_restore_en, redirect_valid}, redirect_pc, target);
        end
      end
      $display("txn %0d target=%h drain=%0d drop_rel=%0d gap=%0d errors=%0d", t, target, d, drop_rel, gap, bad);
      prev_target = target;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_drain_busy();
    test_dropped();
    test_reset_midway();
    test_req_with_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
